// File: rtl/word_narrow_unit.sv
// word_narrow_unit: narrows an IN_W-bit word to an OUT_W-bit halfword with
// truncate / signed-saturate / unsigned-saturate modes. The narrowing is done
// at accept time. Results sit in an output register backed by one skid
// register, so ready_o depends only on flop state. A sticky flag and a
// saturating counter record overflowing beats.
module word_narrow_unit #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic             ovf_o,
  input  logic             clr_i,
  output logic             sticky_ovf_o,
  output logic [CNT_W-1:0] ovf_cnt_o
);

  localparam logic [1:0]       MODE_SSAT = 2'b01;
  localparam logic [1:0]       MODE_USAT = 2'b10;
  localparam logic [OUT_W-1:0] SAT_SMAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_SMIN  = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] hi_s;   // bits that must all match the result sign
  logic                sfit;
  logic                ufit;
  logic [OUT_W-1:0]    res_n;
  logic                ovf_n;

  logic                skid_full;
  logic [OUT_W-1:0]    skid_data;
  logic                skid_ovf;

  logic                accept;
  logic                xfer;

  assign hi_s    = data_i[IN_W-1:OUT_W-1];
  assign sfit    = (&hi_s) | ~(|hi_s);
  assign ufit    = ~(|data_i[IN_W-1:OUT_W]);
  assign ready_o = ~skid_full;
  assign accept  = valid_i & ready_o;
  assign xfer    = valid_o & ready_i;

  // Narrowing result and overflow flag for the beat on data_i/mode_i.
  always_comb begin
    res_n = data_i[OUT_W-1:0];
    ovf_n = ~sfit;
    case (mode_i)
      MODE_SSAT: if (!sfit) res_n = data_i[IN_W-1] ? SAT_SMIN : SAT_SMAX;
      MODE_USAT: begin
        ovf_n = ~ufit;
        if (!ufit) res_n = '1;
      end
      default: ;
    endcase
  end

  // Output register + skid register. The skid slot only fills while the
  // output register is stalled; it drains into the output on the next transfer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o   <= 1'b0;
      data_o    <= '0;
      ovf_o     <= 1'b0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_ovf  <= 1'b0;
    end else if (skid_full) begin
      // ready_o is low here, so no accept can happen this cycle.
      if (xfer) begin
        data_o    <= skid_data;
        ovf_o     <= skid_ovf;
        skid_full <= 1'b0;
      end
    end else if (accept) begin
      if (valid_o && !ready_i) begin
        skid_full <= 1'b1;
        skid_data <= res_n;
        skid_ovf  <= ovf_n;
      end else begin
        valid_o <= 1'b1;
        data_o  <= res_n;
        ovf_o   <= ovf_n;
      end
    end else if (xfer) begin
      valid_o <= 1'b0;
    end
  end

  // Sticky flag and saturating counter of accepted overflowing beats;
  // clear wins over a same-edge increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sticky_ovf_o <= 1'b0;
      ovf_cnt_o    <= '0;
    end else if (clr_i) begin
      sticky_ovf_o <= 1'b0;
      ovf_cnt_o    <= '0;
    end else if (accept && ovf_n) begin
      sticky_ovf_o <= 1'b1;
      if (ovf_cnt_o != '1) ovf_cnt_o <= ovf_cnt_o + CNT_W'(1);
    end
  end

endmodule
